pw_trigger_seq: RTL and testbench
=================================

# pw_trigger_seq

Multi-pulse trigger sequencer for the PhyWhisperer trigger path. It is the parametrised successor to the single-pulse trigger generator. On an accepted pattern-match event it emits a programmable train of up to pNUM_PULSES pulses on the ChipWhisperer/MCX trigger output. Each pulse has its own delay and width. It also produces an independent delayed capture-enable strobe for fe_capture. It sits between pw_pattern_matcher and the cw_trig/mcx_trig pins, with all settings supplied by reg_pw.

## Interface
Parameters:
- pNUM_PULSES, 8, maximum pulses per sequence (2..16)
- pTRIGGER_DELAY_WIDTH, 20, width of each per-pulse delay field
- pTRIGGER_WIDTH_WIDTH, 17, width of each per-pulse width field
- pCAPTURE_DELAY_WIDTH, 18, width of capture delay
- pIDX_WIDTH (local), $clog2(pNUM_PULSES)

Ports:
- fe_clk  in  1  sole clock (60 MHz front-end clock)
- reset_i  in  1  asynchronous, active-high reset
- I_arm  in  1  level; matches accepted only while high
- I_oneshot  in  1  1 = at most one sequence per arm assertion
- I_trigger_enable  in  1  1 = match starts pulse sequence
- I_match  in  1  single-cycle match pulse from the pattern matcher
- I_num_pulses  in  pIDX_WIDTH+1  pulse count; 0 is treated as 1, values above pNUM_PULSES clamp to pNUM_PULSES
- I_delays  in  pNUM_PULSES*pTRIGGER_DELAY_WIDTH  field k = delay before pulse k
- I_widths  in  pNUM_PULSES*pTRIGGER_WIDTH_WIDTH  field k = width of pulse k
- I_capture_delay  in  pCAPTURE_DELAY_WIDTH  match-to-capture-enable delay
- O_trigger  out  1  registered trigger output
- O_capture_enable_pulse  out  1  one-cycle capture-start strobe
- O_busy  out  1  high while the sequence FSM is not IDLE
- O_pulse_index  out  pIDX_WIDTH  index of the current or next pulse
- O_done  out  1  one-cycle strobe when a full sequence completes

## Operation
- Reset (asynchronous): state IDLE; all outputs 0; counters 0; the oneshot-used flag is cleared.
- Accepted match: I_match=1 and I_arm=1, state IDLE, and (I_oneshot=0 or the used flag is clear).
  - The capture counter always loads I_capture_delay on an accepted match.
  - If I_trigger_enable=1, the pulse FSM also starts. If I_trigger_enable=0, only the capture counter runs.
  - The used flag is set when the FSM starts. It clears whenever I_arm=0.
- FSM states are IDLE, DELAY, HIGH, DONE. A single down-counter cnt (max of the two field widths) serves both DELAY and HIGH.
  - IDLE → DELAY: on accepted match with enable; idx=0; cnt=delay[0].
  - DELAY:
    - cnt==0: O_trigger←1; cnt=max(width[idx],1)−1; go to HIGH.
    - otherwise: cnt−1.
  - HIGH:
    - cnt==0: O_trigger←0. If idx==N−1, go to DONE. Otherwise idx+1, cnt=max(delay[idx+1],1)−1, go to DELAY.
    - otherwise: cnt−1.
  - DONE: O_done=1 for this cycle; go to IDLE.
- N = the clamped I_num_pulses. I_num_pulses, I_delays and I_widths are sampled as used (field k is read when pulse k is loaded). Software changes them only while O_busy=0.
- Abort: I_arm=0 in DELAY or HIGH. Next edge: O_trigger←0, state IDLE, no O_done, idx←0. The capture counter is also cancelled.
- Capture counter is independent of the FSM:
  - It is active after load. At zero it pulses O_capture_enable_pulse for 1 cycle and goes inactive; otherwise it decrements.
  - An accepted match while it is still active reloads it. Only the latest match produces a strobe.
- O_busy = (state≠IDLE), registered alongside the state.
- O_pulse_index = idx.

## Timing
- Edge E0 = the edge sampling the accepted match.
- First pulse: O_trigger is high after edge E0+delay[0]+1. delay[0]=0 gives 1-cycle latency.
- Pulse k is high for max(width[k],1) cycles.
- Low gap before pulse k≥1 is max(delay[k],1) cycles. Consecutive pulses never merge.
- O_done is high in the cycle after the last falling edge of O_trigger. O_busy falls on the following edge.
- Earliest re-acceptance is the cycle after O_done, or the cycle after abort.
- O_capture_enable_pulse is high after edge E0+I_capture_delay+1, for exactly 1 cycle.
- Counters never wrap. Full-scale delay and width values give 2^W cycles of delay and 2^W−1 cycles of width.
- I_match while busy: ignored by the FSM and by the capture counter.
- I_match coincident with abort (I_arm=0): not accepted.

## Test plan
- Single pulse: N=1, delay[0]=0, width[0]=4, match at E0 -> O_trigger high E1..E5 (4 cycles); O_done at E5; O_busy low at E6.
- Train: N=3, delays {10,2,0}, widths {3,1,0} -> highs of 3/1/1 cycles; low gaps of 2 and 1 cycles; O_pulse_index steps 0,1,2; one O_done.
- Clamp and zero: I_num_pulses=0 gives 1 pulse; I_num_pulses=pNUM_PULSES+3 gives pNUM_PULSES pulses.
- Capture strobe: capture_delay=100, trigger_enable=0 -> no O_trigger; one strobe exactly 101 cycles after E0; a second match at E0+50 moves the strobe to E0+151.
- Oneshot/abort: I_oneshot=1, two matches in one arm window -> one sequence only. Drop I_arm mid-HIGH -> O_trigger low next cycle, no O_done, re-arm accepts.
- Async reset asserted mid-DELAY -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: on an accepted match, emits a train of up to
// pNUM_PULSES programmable pulses plus an independent delayed capture strobe.
// Latency: first pulse rises delay[0]+1 edges after the match edge; no backpressure (free-running).
//
// Ports:
//   fe_clk                 - sole clock (front-end clock)
//   reset_i                - asynchronous active-high reset
//   I_arm                  - level; matches accepted only while high, low aborts a running train
//   I_oneshot              - 1 = at most one sequence per arm assertion
//   I_trigger_enable       - 1 = accepted match also starts the pulse train
//   I_match                - single-cycle match pulse from the pattern matcher
//   I_num_pulses           - pulse count (0 -> 1, clamped to pNUM_PULSES)
//   I_delays / I_widths    - packed per-pulse delay / width fields, field k for pulse k
//   I_capture_delay        - match-to-capture-strobe delay
//   O_trigger              - registered trigger output
//   O_capture_enable_pulse - one-cycle capture-start strobe
//   O_busy                 - high while the sequence FSM is not IDLE
//   O_pulse_index          - index of the current or next pulse
//   O_done                 - one-cycle strobe when a full sequence completes

module pw_trigger_seq #(
    parameter int pNUM_PULSES          = 8,
    parameter int pTRIGGER_DELAY_WIDTH = 20,
    parameter int pTRIGGER_WIDTH_WIDTH = 17,
    parameter int pCAPTURE_DELAY_WIDTH = 18,
    localparam int pIDX_WIDTH          = $clog2(pNUM_PULSES)
) (
    input  logic                                            fe_clk,
    input  logic                                            reset_i,
    input  logic                                            I_arm,
    input  logic                                            I_oneshot,
    input  logic                                            I_trigger_enable,
    input  logic                                            I_match,
    input  logic [pIDX_WIDTH:0]                             I_num_pulses,
    input  logic [pNUM_PULSES*pTRIGGER_DELAY_WIDTH-1:0]     I_delays,
    input  logic [pNUM_PULSES*pTRIGGER_WIDTH_WIDTH-1:0]     I_widths,
    input  logic [pCAPTURE_DELAY_WIDTH-1:0]                 I_capture_delay,
    output logic                                            O_trigger,
    output logic                                            O_capture_enable_pulse,
    output logic                                            O_busy,
    output logic [pIDX_WIDTH-1:0]                           O_pulse_index,
    output logic                                            O_done
);

    // One shared down-counter serves both the DELAY and HIGH phases, so it
    // must hold the wider of the two field types.
    localparam int CNT_W = (pTRIGGER_DELAY_WIDTH > pTRIGGER_WIDTH_WIDTH) ?
                           pTRIGGER_DELAY_WIDTH : pTRIGGER_WIDTH_WIDTH;

    localparam logic [pIDX_WIDTH:0]           MAX_N   = (pIDX_WIDTH+1)'(pNUM_PULSES);
    localparam logic [pIDX_WIDTH:0]           ONE_N   = (pIDX_WIDTH+1)'(1);
    localparam logic [pIDX_WIDTH-1:0]         ONE_IDX = pIDX_WIDTH'(1);
    localparam logic [CNT_W-1:0]              ONE_CNT = CNT_W'(1);
    localparam logic [pCAPTURE_DELAY_WIDTH-1:0] ONE_CAP = pCAPTURE_DELAY_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                          state_q,    state_d;
    logic [CNT_W-1:0]                cnt_q,      cnt_d;
    logic [pIDX_WIDTH-1:0]           idx_q,      idx_d;
    logic                            trig_q,     trig_d;
    logic                            done_q,     done_d;
    logic                            busy_q,     busy_d;
    logic                            used_q,     used_d;
    logic                            cap_act_q,  cap_act_d;
    logic [pCAPTURE_DELAY_WIDTH-1:0] cap_cnt_q,  cap_cnt_d;
    logic                            cap_pls_q,  cap_pls_d;

    // ------------------------------------------------------------------
    // Per-pulse field unpacking
    // ------------------------------------------------------------------
    logic [pTRIGGER_DELAY_WIDTH-1:0] delay_arr [pNUM_PULSES];
    logic [pTRIGGER_WIDTH_WIDTH-1:0] width_arr [pNUM_PULSES];

    for (genvar g = 0; g < pNUM_PULSES; g++) begin : g_fields
        assign delay_arr[g] = I_delays[g*pTRIGGER_DELAY_WIDTH +: pTRIGGER_DELAY_WIDTH];
        assign width_arr[g] = I_widths[g*pTRIGGER_WIDTH_WIDTH +: pTRIGGER_WIDTH_WIDTH];
    end

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [pIDX_WIDTH:0]   n_eff;
    logic [pIDX_WIDTH:0]   n_eff_m1;
    logic [pIDX_WIDTH-1:0] idx_nxt;
    logic                  last_pulse;
    logic [CNT_W-1:0]      width_ld;
    logic [CNT_W-1:0]      gap_ld;
    logic                  accept;
    logic                  start;
    logic                  abort;

    always_comb begin
        if (I_num_pulses == '0) begin
            n_eff = ONE_N;
        end else if (I_num_pulses > MAX_N) begin
            n_eff = MAX_N;
        end else begin
            n_eff = I_num_pulses;
        end
    end

    assign n_eff_m1   = n_eff - ONE_N;
    assign last_pulse = ({1'b0, idx_q} == n_eff_m1);
    assign idx_nxt    = idx_q + ONE_IDX;

    // HIGH loads width-1 (min 1 cycle). The next gap loads delay-1 (min 1
    // cycle) so back-to-back pulses always have a low cycle between them.
    assign width_ld = (width_arr[idx_q] == '0) ? '0 :
                      (CNT_W'(width_arr[idx_q]) - ONE_CNT);
    assign gap_ld   = (delay_arr[idx_nxt] == '0) ? '0 :
                      (CNT_W'(delay_arr[idx_nxt]) - ONE_CNT);

    assign accept = I_match && I_arm && (state_q == ST_IDLE) &&
                    (!I_oneshot || !used_q);
    assign start  = accept && I_trigger_enable;
    assign abort  = !I_arm && ((state_q == ST_DELAY) || (state_q == ST_HIGH));

    // ------------------------------------------------------------------
    // Pulse-train FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        trig_d  = trig_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                trig_d = 1'b0;
                idx_d  = '0;
                if (start) begin
                    state_d = ST_DELAY;
                    cnt_d   = CNT_W'(delay_arr[0]);
                end
            end

            ST_DELAY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    trig_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    trig_d  = 1'b1;
                    cnt_d   = width_ld;
                end else begin
                    cnt_d = cnt_q - ONE_CNT;
                end
            end

            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    trig_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    trig_d = 1'b0;
                    if (last_pulse) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        idx_d   = idx_nxt;
                        cnt_d   = gap_ld;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_CNT;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                trig_d  = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Busy tracks the registered state, so it is computed from the next state.
    assign busy_d = (state_d != ST_IDLE);

    // The oneshot flag latches on a started train and releases only on disarm.
    always_comb begin
        used_d = used_q;
        if (!I_arm) begin
            used_d = 1'b0;
        end else if (start) begin
            used_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture-enable counter: independent of the pulse FSM. A new accepted
    // match reloads it, so only the most recent match produces a strobe.
    // ------------------------------------------------------------------
    always_comb begin
        cap_act_d = cap_act_q;
        cap_cnt_d = cap_cnt_q;
        cap_pls_d = 1'b0;

        if (accept) begin
            cap_act_d = 1'b1;
            cap_cnt_d = I_capture_delay;
        end else if (abort) begin
            cap_act_d = 1'b0;
            cap_cnt_d = '0;
        end else if (cap_act_q) begin
            if (cap_cnt_q == '0) begin
                cap_pls_d = 1'b1;
                cap_act_d = 1'b0;
            end else begin
                cap_cnt_d = cap_cnt_q - ONE_CAP;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            used_q    <= 1'b0;
            cap_act_q <= 1'b0;
            cap_cnt_q <= '0;
            cap_pls_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            used_q    <= used_d;
            cap_act_q <= cap_act_d;
            cap_cnt_q <= cap_cnt_d;
            cap_pls_q <= cap_pls_d;
        end
    end

    assign O_trigger              = trig_q;
    assign O_capture_enable_pulse = cap_pls_q;
    assign O_busy                 = busy_q;
    assign O_pulse_index          = idx_q;
    assign O_done                 = done_q;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Directed bench for pw_trigger_seq: single pulse, train, clamp, capture strobe,
// oneshot, abort and asynchronous reset, each against hand-computed traces.
// Trace index k holds the outputs sampled 1 ns after edge E0+k.

module tb_pw_trigger_seq;

    localparam int NP  = 8;
    localparam int DW  = 20;
    localparam int WW  = 17;
    localparam int CW  = 18;
    localparam int IW  = $clog2(NP);

    logic                 fe_clk = 1'b0;
    logic                 reset_i;
    logic                 I_arm;
    logic                 I_oneshot;
    logic                 I_trigger_enable;
    logic                 I_match;
    logic [IW:0]          I_num_pulses;
    logic [NP*DW-1:0]     I_delays;
    logic [NP*WW-1:0]     I_widths;
    logic [CW-1:0]        I_capture_delay;
    logic                 O_trigger;
    logic                 O_capture_enable_pulse;
    logic                 O_busy;
    logic [IW-1:0]        O_pulse_index;
    logic                 O_done;

    pw_trigger_seq #(
        .pNUM_PULSES          (NP),
        .pTRIGGER_DELAY_WIDTH (DW),
        .pTRIGGER_WIDTH_WIDTH (WW),
        .pCAPTURE_DELAY_WIDTH (CW)
    ) dut (
        .fe_clk                 (fe_clk),
        .reset_i                (reset_i),
        .I_arm                  (I_arm),
        .I_oneshot              (I_oneshot),
        .I_trigger_enable       (I_trigger_enable),
        .I_match                (I_match),
        .I_num_pulses           (I_num_pulses),
        .I_delays               (I_delays),
        .I_widths               (I_widths),
        .I_capture_delay        (I_capture_delay),
        .O_trigger              (O_trigger),
        .O_capture_enable_pulse (O_capture_enable_pulse),
        .O_busy                 (O_busy),
        .O_pulse_index          (O_pulse_index),
        .O_done                 (O_done)
    );

    always #5 fe_clk = ~fe_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] tr_trig;
    logic [255:0] tr_done;
    logic [255:0] tr_busy;
    logic [255:0] tr_cap;
    int           tr_idx [256];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge fe_clk);
        #1;
    endtask

    function automatic int first_set(input logic [255:0] v);
        for (int i = 0; i < 256; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_fields();
        I_delays = '0;
        I_widths = '0;
    endtask

    task automatic set_pulse(input int k, input int d, input int w);
        I_delays[k*DW +: DW] = DW'(d);
        I_widths[k*WW +: WW] = WW'(w);
    endtask

    task automatic sample(input int k);
        tr_trig[k] = O_trigger;
        tr_done[k] = O_done;
        tr_busy[k] = O_busy;
        tr_cap[k]  = O_capture_enable_pulse;
        tr_idx[k]  = int'(O_pulse_index);
    endtask

    // Fires I_match into edge E0, then records ncyc samples. A second match
    // can be injected at edge rematch_k and I_arm dropped from edge armdrop_k.
    task automatic run_trace(input int ncyc, input int rematch_k, input int armdrop_k);
        tr_trig = '0;
        tr_done = '0;
        tr_busy = '0;
        tr_cap  = '0;
        I_match = 1'b1;
        step();
        sample(0);
        for (int k = 1; k < ncyc; k++) begin
            I_match = (k == rematch_k);
            if (k == armdrop_k) I_arm = 1'b0;
            step();
            sample(k);
        end
        I_match = 1'b0;
    endtask

    task automatic disarm_cycle();
        I_arm = 1'b0;
        step();
        I_arm = 1'b1;
        step();
    endtask

    initial begin
        reset_i          = 1'b1;
        I_arm            = 1'b0;
        I_oneshot        = 1'b0;
        I_trigger_enable = 1'b0;
        I_match          = 1'b0;
        I_num_pulses     = '0;
        I_delays         = '0;
        I_widths         = '0;
        I_capture_delay  = '0;
        #12;
        chk("reset_trig", 64'(O_trigger), 64'd0);
        chk("reset_busy", 64'(O_busy), 64'd0);
        chk("reset_done", 64'(O_done), 64'd0);
        chk("reset_cap",  64'(O_capture_enable_pulse), 64'd0);
        chk("reset_idx",  64'(O_pulse_index), 64'd0);
        @(negedge fe_clk);
        reset_i = 1'b0;
        step();
        I_arm = 1'b1;
        I_trigger_enable = 1'b1;
        I_capture_delay = CW'(200);

        // Single pulse: delay 0, width 4.
        clear_fields();
        I_num_pulses = 1;
        set_pulse(0, 0, 4);
        run_trace(16, -1, -1);
        chk("single_trig", 64'(tr_trig[31:0]), 64'h1E);
        chk("single_done", 64'(tr_done[31:0]), 64'h20);
        chk("single_busy", 64'(tr_busy[31:0]), 64'h3F);

        // Train: delays {10,2,0}, widths {3,1,0}.
        repeat (4) step();
        clear_fields();
        I_num_pulses = 3;
        set_pulse(0, 10, 3);
        set_pulse(1, 2, 1);
        set_pulse(2, 0, 0);
        run_trace(32, -1, -1);
        chk("train_trig", 64'(tr_trig[31:0]), 64'h53800);
        chk("train_done", 64'(tr_done[31:0]), 64'h80000);
        chk("train_busy", 64'(tr_busy[31:0]), 64'hFFFFF);
        chk("train_idx0", 64'(tr_idx[12]), 64'd0);
        chk("train_idx1a", 64'(tr_idx[14]), 64'd1);
        chk("train_idx1b", 64'(tr_idx[16]), 64'd1);
        chk("train_idx2", 64'(tr_idx[18]), 64'd2);

        // Pulse count 0 behaves as 1.
        clear_fields();
        for (int k = 0; k < NP; k++) set_pulse(k, 0, 1);
        I_num_pulses = 0;
        run_trace(32, -1, -1);
        chk("zero_n_trig", 64'(tr_trig[31:0]), 64'h2);
        chk("zero_n_done", 64'(tr_done[31:0]), 64'h4);

        // Pulse count above the maximum clamps to NP pulses.
        repeat (2) step();
        I_num_pulses = NP + 3;
        run_trace(32, -1, -1);
        chk("clamp_trig", 64'(tr_trig[31:0]), 64'hAAAA);
        chk("clamp_done", 64'(tr_done[31:0]), 64'h10000);
        chk("clamp_npulse", 64'($countones(tr_trig & ~(tr_trig << 1))), 64'd8);

        // Capture strobe only: no trigger, strobe 101 cycles after E0.
        repeat (4) step();
        I_trigger_enable = 1'b0;
        I_capture_delay  = CW'(100);
        run_trace(200, -1, -1);
        chk("cap_first", 64'(first_set(tr_cap)), 64'd101);
        chk("cap_count", 64'($countones(tr_cap)), 64'd1);
        chk("cap_no_trig", 64'($countones(tr_trig)), 64'd0);
        chk("cap_no_busy", 64'($countones(tr_busy)), 64'd0);

        // Second match at E0+50 moves the single strobe to E0+151.
        run_trace(200, 50, -1);
        chk("cap_re_first", 64'(first_set(tr_cap)), 64'd151);
        chk("cap_re_count", 64'($countones(tr_cap)), 64'd1);

        // Oneshot: second match in the same arm window is ignored.
        I_trigger_enable = 1'b1;
        I_capture_delay  = CW'(200);
        clear_fields();
        I_num_pulses = 1;
        set_pulse(0, 0, 2);
        I_oneshot = 1'b1;
        disarm_cycle();
        run_trace(12, 6, -1);
        chk("oneshot_trig", 64'(tr_trig[31:0]), 64'h6);
        chk("oneshot_done", 64'($countones(tr_done)), 64'd1);

        // Same stimulus without oneshot runs twice.
        I_oneshot = 1'b0;
        run_trace(12, 6, -1);
        chk("repeat_trig", 64'(tr_trig[31:0]), 64'h186);
        chk("repeat_done", 64'($countones(tr_done)), 64'd2);

        // Match while disarmed is not accepted.
        repeat (4) step();
        I_arm = 1'b0;
        run_trace(8, -1, -1);
        chk("disarmed_busy", 64'($countones(tr_busy)), 64'd0);
        I_arm = 1'b1;
        step();

        // Abort mid-HIGH: trigger low next cycle, no done, capture cancelled.
        clear_fields();
        I_num_pulses = 1;
        set_pulse(0, 3, 10);
        I_capture_delay = CW'(20);
        run_trace(30, -1, 7);
        chk("abort_trig", 64'(tr_trig[31:0]), 64'h70);
        chk("abort_busy", 64'(tr_busy[31:0]), 64'h7F);
        chk("abort_done", 64'($countones(tr_done)), 64'd0);
        chk("abort_cap",  64'($countones(tr_cap)), 64'd0);

        // Re-arm is accepted; short capture delay strobes at E0+3.
        I_arm = 1'b1;
        step();
        set_pulse(0, 0, 1);
        I_capture_delay = CW'(2);
        run_trace(8, -1, -1);
        chk("rearm_trig", 64'(tr_trig[7:0]), 64'h2);
        chk("rearm_cap",  64'(first_set(tr_cap)), 64'd3);

        // Asynchronous reset while waiting in DELAY before pulse 1.
        repeat (4) step();
        clear_fields();
        I_num_pulses = 2;
        set_pulse(0, 0, 2);
        set_pulse(1, 20, 1);
        I_capture_delay = CW'(50);
        I_match = 1'b1;
        step();
        I_match = 1'b0;
        repeat (5) step();
        chk("pre_rst_busy", 64'(O_busy), 64'd1);
        chk("pre_rst_idx",  64'(O_pulse_index), 64'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_busy", 64'(O_busy), 64'd0);
        chk("async_rst_idx",  64'(O_pulse_index), 64'd0);
        chk("async_rst_trig", 64'(O_trigger), 64'd0);
        step();
        reset_i = 1'b0;
        tr_trig = '0;
        tr_cap  = '0;
        for (int k = 0; k < 60; k++) begin
            step();
            sample(k);
        end
        chk("post_rst_trig", 64'($countones(tr_trig)), 64'd0);
        chk("post_rst_cap",  64'($countones(tr_cap)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
